// File: rtl/wordle_if.sv
// Scoring request/response bundle between guess entry, scorer and display.
interface wordle_if #(
    parameter int LETTERS  = 5,
    parameter int LETTER_W = 8
);
    logic                         start;
    logic [LETTERS*LETTER_W-1:0]  guess;
    logic [LETTERS*LETTER_W-1:0]  answer;
    logic                         busy;
    logic                         done;
    logic [2*LETTERS-1:0]         result;
    logic                         all_green;

    modport master (
        output start, guess, answer,
        input  busy, done, result, all_green
    );

    modport slave (
        input  start, guess, answer,
        output busy, done, result, all_green
    );
endinterface

// File: rtl/wordle_scorer.sv
// Sequential Wordle scorer: greens in one cycle, then one (i,j) pair per clock.
// Define SCORER_EARLY_EXIT_EN to end each letter's scan once it is coloured.
module wordle_scorer #(
    parameter int LETTERS  = 5,
    parameter int LETTER_W = 8
) (
    input  logic    Clk,
    input  logic    reset,
    wordle_if.slave bus
);
    localparam int CW = (LETTERS > 1) ? $clog2(LETTERS) : 1;
    localparam logic [CW-1:0] LAST = CW'(LETTERS - 1);

    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        GREEN  = 4'b0010,
        YELLOW = 4'b0100,
        DONE   = 4'b1000
    } state_t;

    state_t state_q, state_n;

    logic [LETTERS-1:0][LETTER_W-1:0] g_q, g_n, a_q, a_n;
    logic [LETTERS-1:0][1:0]          work_q, work_n;
    logic [LETTERS-1:0]               used_q, used_n;
    logic [CW-1:0]                    i_q, i_n, j_q, j_n;
    logic [2*LETTERS-1:0]             res_q, res_n;
    logic                             ag_q, ag_n;
    logic                             hit;
    logic                             skip;

    always_comb begin
        state_n = state_q;
        g_n     = g_q;
        a_n     = a_q;
        work_n  = work_q;
        used_n  = used_q;
        i_n     = i_q;
        j_n     = j_q;
        res_n   = res_q;
        ag_n    = ag_q;
        hit     = 1'b0;
        skip    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    for (int k = 0; k < LETTERS; k++) begin
                        g_n[k] = bus.guess[(LETTERS-1-k)*LETTER_W +: LETTER_W];
                        a_n[k] = bus.answer[(LETTERS-1-k)*LETTER_W +: LETTER_W];
                    end
                    work_n  = '0;
                    used_n  = '0;
                    state_n = GREEN;
                end
            end
            GREEN: begin
                for (int k = 0; k < LETTERS; k++) begin
                    if (g_q[k] == a_q[k]) begin
                        work_n[k] = 2'b10;
                        used_n[k] = 1'b1;
                    end
                end
                i_n     = '0;
                j_n     = '0;
                state_n = YELLOW;
            end
            YELLOW: begin
                hit = (work_q[i_q] == 2'b00) && !used_q[j_q] &&
                      (g_q[i_q] == a_q[j_q]) && (j_q != i_q);
                if (hit) begin
                    work_n[i_q] = 2'b01;
                    used_n[j_q] = 1'b1;
                end
`ifdef SCORER_EARLY_EXIT_EN
                skip = hit || (work_q[i_q] != 2'b00);
`else
                skip = 1'b0;
`endif
                if ((j_q == LAST) || skip) begin
                    j_n = '0;
                    if (i_q == LAST) begin
                        // Publish work_n so the final pair's update is included.
                        for (int k = 0; k < LETTERS; k++)
                            res_n[2*(LETTERS-1-k) +: 2] = work_n[k];
                        ag_n    = (res_n == {LETTERS{2'b10}});
                        state_n = DONE;
                    end else begin
                        i_n = i_q + CW'(1);
                    end
                end else begin
                    j_n = j_q + CW'(1);
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q <= IDLE;
            g_q     <= '0;
            a_q     <= '0;
            work_q  <= '0;
            used_q  <= '0;
            i_q     <= '0;
            j_q     <= '0;
            res_q   <= '0;
            ag_q    <= 1'b0;
        end else begin
            state_q <= state_n;
            g_q     <= g_n;
            a_q     <= a_n;
            work_q  <= work_n;
            used_q  <= used_n;
            i_q     <= i_n;
            j_q     <= j_n;
            res_q   <= res_n;
            ag_q    <= ag_n;
        end
    end

    assign bus.busy      = (state_q == GREEN) || (state_q == YELLOW);
    assign bus.done      = (state_q == DONE);
    assign bus.result    = res_q;
    assign bus.all_green = ag_q;
endmodule

// File: tb/tb_wordle_scorer.sv
// Scoreboard bench for wordle_scorer: directed words, stream and reset cases.
module tb_wordle_scorer;
    logic Clk;
    logic reset;
    int   cyc;
    int   n_cmp;
    int   n_err;

    wordle_if #(.LETTERS(5), .LETTER_W(8)) bus ();

    wordle_scorer #(.LETTERS(5), .LETTER_W(8)) dut (
        .Clk   (Clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [9:0] r;
        logic       ag;
        int         at;
    } exp_t;

    exp_t exp_q[$];

`ifdef SCORER_EARLY_EXIT_EN
    localparam int LAT_CRANE = 6;
    localparam int LAT_VAR   = -1;
`else
    localparam int LAT_CRANE = 26;
    localparam int LAT_VAR   = 26;
`endif

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_cmp = n_cmp + 1;
        if (act !== req) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    always @(negedge Clk) begin
        exp_t e;
        if (!reset && bus.done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("result", {22'd0, bus.result}, {22'd0, e.r});
                chk("all_green", {31'd0, bus.all_green}, {31'd0, e.ag});
                if (e.at >= 0)
                    chk("done_edge", cyc, e.at);
            end
        end
    end

    task automatic launch(input logic [39:0] g, input logic [39:0] a,
                          input logic [9:0] r, input int lat,
                          input bit push);
        exp_t e;
        @(negedge Clk);
        bus.guess  = g;
        bus.answer = a;
        bus.start  = 1'b1;
        if (push) begin
            e.r  = r;
            e.ag = (r == 10'h2AA);
            e.at = (lat >= 0) ? cyc + 1 + lat : -1;
            exp_q.push_back(e);
        end
        @(negedge Clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (n < 200 && (bus.busy || bus.done || exp_q.size() != 0)) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 200)
            chk("timeout", 32'd1, 32'd0);
    endtask

    initial begin
        cyc        = 0;
        n_cmp      = 0;
        n_err      = 0;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.guess  = '0;
        bus.answer = '0;
        repeat (3) @(negedge Clk);
        reset = 1'b0;
        @(negedge Clk);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_result", {22'd0, bus.result}, 32'd0);
        chk("rst_all_green", {31'd0, bus.all_green}, 32'd0);

        launch("CRANE", "CRANE", 10'h2AA, LAT_CRANE, 1'b1);
        chk("busy_edge0", {31'd0, bus.busy}, 32'd1);
        for (int k = 1; k < LAT_CRANE; k++) begin
            @(negedge Clk);
            chk("busy_run", {31'd0, bus.busy}, 32'd1);
        end
        @(negedge Clk);
        chk("busy_at_done", {31'd0, bus.busy}, 32'd0);
        wait_idle();

        // Extra starts and input changes mid-run must not disturb scoring.
        launch("MOIST", "CRANE", 10'h000, 26, 1'b1);
        bus.guess = "CRANE";
        for (int k = 1; k <= 12; k++) begin
            @(negedge Clk);
            if (k == 4 || k == 11) bus.start = 1'b1;
            if (k == 5 || k == 12) bus.start = 1'b0;
            if (k == 8) begin
                chk("hold_result", {22'd0, bus.result}, 32'h2AA);
                chk("hold_all_green", {31'd0, bus.all_green}, 32'd1);
            end
        end
        wait_idle();
        repeat (30) @(negedge Clk);

        launch("BOBBY", "ABBEY", 10'h122, LAT_VAR, 1'b1);
        wait_idle();
        launch("EERIE", "CRANE", 10'h012, LAT_VAR, 1'b1);
        wait_idle();
        launch("crane", "CRANE", 10'h000, 26, 1'b1);
        wait_idle();
        launch("CRANE", "CRANE", 10'h2AA, LAT_CRANE, 1'b1);
        wait_idle();

        launch("NACRE", "CRANE", 10'h000, 0, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            @(negedge Clk);
            if (k == 5)
                chk("pre_rst_result", {22'd0, bus.result}, 32'h2AA);
        end
        reset = 1'b1;
        @(negedge Clk);
        reset = 1'b0;
        chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("mid_rst_done", {31'd0, bus.done}, 32'd0);
        chk("mid_rst_result", {22'd0, bus.result}, 32'd0);
        chk("mid_rst_all_green", {31'd0, bus.all_green}, 32'd0);
        repeat (30) @(negedge Clk);

        launch("NACRE", "CRANE", 10'h156, LAT_VAR, 1'b1);
        wait_idle();
        launch("LLAMA", "ALLOY", 10'h190, LAT_VAR, 1'b1);
        wait_idle();
        repeat (5) @(negedge Clk);

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, required finished");
        $fatal(1, "global timeout");
    end
endmodule
